// File: rtl/arith_pkg.sv
// Shared arithmetic-cluster definitions: control states, default operand width
// and a constant-evaluable ceiling log2.
package arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEFAULT_N = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_divider_128by64_div_step.sv
// One radix-2 restoring division iteration, purely combinational, so it can be
// replicated for an unrolled higher-radix datapath.
module div_step #(
  parameter int N = 64
) (
  input  logic [N:0]   pr,
  input  logic [N-1:0] q,
  input  logic [N-1:0] divisor,
  output logic [N:0]   pr_next,
  output logic [N-1:0] q_next
);

  logic        [N+1:0] t;
  logic signed [N+1:0] diff;

  // Trial subtraction carried one bit wider than PR so its sign is exact.
  always_comb begin
    t    = {pr, q[N-1]};
    diff = signed'(t) - signed'({2'b00, divisor});
    if (!diff[N+1]) begin
      pr_next = diff[N:0];
      q_next  = {q[N-2:0], 1'b1};
    end else begin
      pr_next = t[N:0];
      q_next  = {q[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider_128by64.sv
// Sequential 2N-by-N unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes on operands and results.
module seq_divider_128by64
  import arith_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;

  logic [N:0]    pr_p0;
  logic [N-1:0]  q_p0;
  logic [N-1:0]  dvsr_p0;
  logic [N:0]    pr_next;
  logic [N-1:0]  q_next;

  assign accept = in_valid && in_ready;

  div_step #(.N(N)) u_step (
    .pr      (pr_p0),
    .q       (q_p0),
    .divisor (dvsr_p0),
    .pr_next (pr_next),
    .q_next  (q_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready    <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[N-1:0];
            end else if (dividend[2*N-1:N] >= divisor) begin
              // Quotient would need more than N bits.
              state     <= DONE;
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
            end else begin
              state <= RUN;
              cnt   <= CW'(N);
            end
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_next;
            remainder <= pr_next[N-1:0];
          end
        end
        DONE: begin
          // Error results arrive here with out_valid low; raise it one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Iteration datapath: loaded on acceptance, stepped once per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      pr_p0   <= {1'b0, dividend[2*N-1:N]};
      q_p0    <= dividend[N-1:0];
      dvsr_p0 <= divisor;
    end else if (state == RUN) begin
      pr_p0 <= pr_next;
      q_p0  <= q_next;
    end
  end

endmodule

// File: tb/tb_seq_divider_128by64.sv
// Scoreboard bench for seq_divider_128by64: directed, error, backpressure,
// reset-abort and random back-to-back traffic.
module tb_seq_divider_128by64;

  localparam int N     = 64;
  localparam int NRAND = 300;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  always #5 clk = ~clk;

  seq_divider_128by64 #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ov;
  } res_t;

  res_t sb[$];
  res_t mon_e;
  res_t bp_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_xfer = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic res_t model(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    res_t e;
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (dv == '0) begin
      e.dz = 1'b1;
      e.q  = '1;
      e.r  = dd[N-1:0];
    end else if (dd[2*N-1:N] >= dv) begin
      e.ov = 1'b1;
      e.q  = '1;
      e.r  = '0;
    end else begin
      e.q = N'(dd / {{N{1'b0}}, dv});
      e.r = N'(dd % {{N{1'b0}}, dv});
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_xfer++;
      if (sb.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", div_by_zero, mon_e.dz);
        chk("overflow", overflow, mon_e.ov);
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [2*N-1:0] dd, input logic [N-1:0] dv, input int exp_lat);
    int k;
    int lat;
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    sb.push_back(model(dd, dv));
    #1 in_valid = 1'b0;
    lat = -1;
    for (k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, exp_lat);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            k;
    int            xfer0;
    logic [N-1:0]  dv;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    chk("rst_ov", overflow, 0);
    rst_n = 1'b1;

    // Abort a running division with reset.
    @(posedge clk);
    #1;
    dividend = 128'h64;
    divisor  = 64'h7;
    in_valid = 1'b1;
    @(negedge clk);
    chk("mid_accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_quotient", quotient, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(128'd100, 64'd7, N);
    do_op(128'hFFFFFFFFFFFFFFFD_0000000000000002, 64'hFFFF_FFFF_FFFF_FFFE, N);
    do_op(128'h1234, 64'h0, 1);
    do_op(128'h5_0000000000000000, 64'h5, 1);

    // Backpressure: result must hold and new operands must be ignored.
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    bp_e = model(128'h0000000000000002_123456789ABCDEF0, 64'h1_0000_0001);
    do_op(128'h0000000000000002_123456789ABCDEF0, 64'h1_0000_0001, N);
    for (int c = 0; c < 20; c++) begin
      dividend = {$urandom(), $urandom(), $urandom(), $urandom()};
      divisor  = 64'(c);
      in_valid = c[0];
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_quotient", quotient, bp_e.q);
      chk("bp_remainder", remainder, bp_e.r);
    end
    in_valid  = 1'b0;
    xfer0     = n_xfer;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_xfers", n_xfer - xfer0, 1);

    // Random back-to-back traffic with in_valid held high.
    in_valid = 1'b1;
    for (int i = 0; i < NRAND; i++) begin
      dv = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if (dv == '0) dv = 64'd1;
      hi = {$urandom(), $urandom()} % dv;
      if (i % 7 == 0) hi = dv - 64'd1;
      lo = {$urandom(), $urandom()};
      dividend = {hi, lo};
      divisor  = dv;
      wait_ready();
      @(posedge clk);
      sb.push_back(model({hi, lo}, dv));
      #1;
    end
    in_valid = 1'b0;

    k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
